fdma_stream_writer: RTL and testbench

//  Upstream feeder for the FDMA write channel: accepts a 32-bit valid/ready stream on ui_clk,

---
 rtl/fdma_stream_writer.sv | 203 ++++++++++++++++++++
 tb/tb_fdma_stream_writer.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fdma_stream_writer.sv
// Packs a 32-bit stream into 128-bit beats in a FWFT FIFO and issues fixed-length FDMA write bursts.
// Latency: a beat is visible in fifo_level one cycle after its 4th word; wareq rises one cycle after the start condition.
// Backpressure: s_ready drops only when the FIFO is full and the packer holds 3 words.
module fdma_stream_writer #(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter logic [31:0] BUF_SIZE       = 32'h0100_0000,
    parameter logic [15:0] FDMA_BURST_LEN = 16'd512,
    parameter int          FIFO_AW        = 10
) (
    input  logic               ui_clk,
    input  logic               ui_rst,
    input  logic               enable,
    input  logic               s_valid,
    input  logic [31:0]        s_data,
    output logic               s_ready,
    output logic [31:0]        fdma_waddr,
    output logic               fdma_wareq,
    output logic [15:0]        fdma_wsize,
    input  logic               fdma_wbusy,
    input  logic               fdma_wvalid,
    output logic [127:0]       fdma_wdata,
    output logic               fdma_wready,
    output logic [FIFO_AW:0]   fifo_level,
    output logic [31:0]        burst_cnt,
    output logic               underflow
);

    localparam int                 DEPTH       = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0]   FULL_LVL    = DEPTH;
    localparam logic [FIFO_AW:0]   LVL_ONE     = 1;
    localparam logic [FIFO_AW-1:0] PTR_ONE     = 1;
    localparam logic [31:0]        BURST_BYTES = {12'd0, FDMA_BURST_LEN, 4'd0};
    localparam logic [31:0]        BUF_END     = BASE_ADDR + BUF_SIZE;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_BUSY = 2'd2,
        ST_ADV  = 2'd3
    } state_t;

    // Packer state: lanes 0..2 are held here until the 4th word completes a beat.
    logic [1:0]          lane_q, lane_d;
    logic [95:0]         pack_q, pack_d;

    // FIFO state.
    logic [127:0]        mem_q [DEPTH];
    logic [FIFO_AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]    level_q, level_d;
    logic                underflow_q, underflow_d;

    // Burst control state.
    state_t              state_q, state_d;
    logic                wareq_q, wareq_d;
    logic [31:0]         waddr_q, waddr_d;
    logic [31:0]         burst_cnt_q, burst_cnt_d;

    logic                fifo_full;
    logic                fifo_empty;
    logic                accept;
    logic                push;
    logic                pop;
    logic [127:0]        push_beat;
    logic [31:0]         next_addr;
    logic                burst_ready;

    assign fifo_full   = (level_q == FULL_LVL);
    assign fifo_empty  = (level_q == '0);
    // A 4th lane is only taken when the FIFO has room, so a push never hits a full FIFO.
    assign s_ready     = !ui_rst && (!fifo_full || (lane_q != 2'd3));
    assign accept      = s_valid && s_ready;
    assign push        = accept && (lane_q == 2'd3);
    assign pop         = fdma_wvalid && !fifo_empty;
    assign push_beat   = {s_data, pack_q};
    assign burst_ready = ({{(31 - FIFO_AW){1'b0}}, level_q} >= {16'd0, FDMA_BURST_LEN});

    assign fdma_wdata  = mem_q[rd_ptr_q];
    assign fdma_wready = 1'b1;
    assign fdma_wsize  = FDMA_BURST_LEN;
    assign fdma_waddr  = waddr_q;
    assign fdma_wareq  = wareq_q;
    assign fifo_level  = level_q;
    assign burst_cnt   = burst_cnt_q;
    assign underflow   = underflow_q;

    // Packer: place each accepted word in its lane, wrap the lane after the 4th word.
    always_comb begin
        lane_d = lane_q;
        pack_d = pack_q;
        if (accept) begin
            case (lane_q)
                2'd0:    pack_d[31:0]  = s_data;
                2'd1:    pack_d[63:32] = s_data;
                2'd2:    pack_d[95:64] = s_data;
                default: pack_d        = pack_q;
            endcase
            lane_d = lane_q + 2'd1;
        end
    end

    // FIFO pointers, occupancy and the sticky underflow flag.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        underflow_d = underflow_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase
        // A pop request against an empty FIFO means the consumer broke the protocol.
        if (fdma_wvalid && fifo_empty) begin
            underflow_d = 1'b1;
        end
    end

    // Next circular-buffer address, wrapping to the base at the end of the region.
    always_comb begin
        next_addr = waddr_q + BURST_BYTES;
        if (next_addr >= BUF_END) begin
            next_addr = BASE_ADDR;
        end
    end

    // Burst FSM: request once a full burst is buffered, track FDMA busy, then advance.
    always_comb begin
        state_d     = state_q;
        wareq_d     = wareq_q;
        waddr_d     = waddr_q;
        burst_cnt_d = burst_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (enable && burst_ready) begin
                    wareq_d = 1'b1;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (wareq_q && fdma_wbusy) begin
                    wareq_d = 1'b0;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (!fdma_wbusy) begin
                    state_d = ST_ADV;
                end
            end
            ST_ADV: begin
                waddr_d     = next_addr;
                burst_cnt_d = burst_cnt_q + 32'd1;
                state_d     = ST_IDLE;
            end
            default: begin
                wareq_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and status registers; reset abandons any burst in flight.
    always_ff @(posedge ui_clk or posedge ui_rst) begin
        if (ui_rst) begin
            lane_q      <= 2'd0;
            pack_q      <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            underflow_q <= 1'b0;
            state_q     <= ST_IDLE;
            wareq_q     <= 1'b0;
            waddr_q     <= BASE_ADDR;
            burst_cnt_q <= 32'd0;
        end else begin
            lane_q      <= lane_d;
            pack_q      <= pack_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            underflow_q <= underflow_d;
            state_q     <= state_d;
            wareq_q     <= wareq_d;
            waddr_q     <= waddr_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    // Beat storage; contents are qualified by the pointers, so no reset is needed.
    always_ff @(posedge ui_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_beat;
        end
    end

endmodule

// File: tb/tb_fdma_stream_writer.sv
// Directed bench for fdma_stream_writer with a simple FDMA write-port model.
// Latency: checks wareq one cycle after the start condition and beat data against the word sequence.
// Backpressure: exercises full-FIFO stall on s_ready and release by the FDMA model.
module tb_fdma_stream_writer;

    localparam logic [31:0] BASE  = 32'h0001_0000;
    localparam logic [31:0] BSIZE = 32'h0000_4000;
    localparam int          BLEN  = 512;

    logic         ui_clk = 1'b0;
    logic         ui_rst = 1'b1;
    logic         enable = 1'b0;
    logic         s_valid = 1'b0;
    logic [31:0]  s_data = 32'd0;
    logic         s_ready;
    logic [31:0]  fdma_waddr;
    logic         fdma_wareq;
    logic [15:0]  fdma_wsize;
    logic         fdma_wbusy;
    logic         fdma_wvalid;
    logic [127:0] fdma_wdata;
    logic         fdma_wready;
    logic [10:0]  fifo_level;
    logic [31:0]  burst_cnt;
    logic         underflow;

    int tests_run = 0;
    int tests_failed = 0;

    // FDMA model state.
    logic         model_en = 1'b0;
    logic         m_busy = 1'b0;
    logic         m_wvalid = 1'b0;
    logic         t_wvalid = 1'b0;
    int           m_beats = 0;
    logic [127:0] got_q[$];
    logic [31:0]  addr_q[$];
    int           push_idx = 0;

    assign fdma_wbusy  = m_busy;
    assign fdma_wvalid = m_wvalid | t_wvalid;

    fdma_stream_writer #(
        .BASE_ADDR(BASE),
        .BUF_SIZE(BSIZE),
        .FDMA_BURST_LEN(16'd512),
        .FIFO_AW(10)
    ) dut (
        .ui_clk(ui_clk), .ui_rst(ui_rst), .enable(enable),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .fdma_waddr(fdma_waddr), .fdma_wareq(fdma_wareq), .fdma_wsize(fdma_wsize),
        .fdma_wbusy(fdma_wbusy), .fdma_wvalid(fdma_wvalid), .fdma_wdata(fdma_wdata),
        .fdma_wready(fdma_wready), .fifo_level(fifo_level), .burst_cnt(burst_cnt),
        .underflow(underflow)
    );

    always #5 ui_clk = ~ui_clk;

    // FDMA model: accept a request by raising wbusy, then pop one beat per cycle for BLEN cycles.
    always @(negedge ui_clk) begin
        if (ui_rst) begin
            m_busy   = 1'b0;
            m_wvalid = 1'b0;
            m_beats  = 0;
        end else if (m_busy) begin
            if (m_beats < BLEN) begin
                m_wvalid = 1'b1;
                got_q.push_back(fdma_wdata);
                m_beats++;
            end else begin
                m_wvalid = 1'b0;
                m_busy   = 1'b0;
            end
        end else if (model_en && fdma_wareq) begin
            m_busy   = 1'b1;
            m_beats  = 0;
            m_wvalid = 1'b0;
            addr_q.push_back(fdma_waddr);
        end
    end

    // Number of popped beats that differ from the word sequence 0,1,2,... packed 4 per beat.
    function automatic int count_bad(input int n);
        int bad;
        logic [127:0] exp;
        bad = (got_q.size() != n) ? 1 : 0;
        for (int k = 0; k < got_q.size(); k++) begin
            exp = {32'(4*k+3), 32'(4*k+2), 32'(4*k+1), 32'(4*k)};
            if (got_q[k] !== exp) bad++;
        end
        return bad;
    endfunction

    task automatic apply_reset();
        @(negedge ui_clk);
        ui_rst   = 1'b1;
        s_valid  = 1'b0;
        t_wvalid = 1'b0;
        model_en = 1'b0;
        enable   = 1'b0;
        repeat (2) @(negedge ui_clk);
        got_q.delete();
        addr_q.delete();
        push_idx = 0;
        ui_rst   = 1'b0;
    endtask

    // Offer words push_idx, push_idx+1, ... one attempt per cycle until n accepted or budget cycles pass.
    task automatic push_words(input int n, input int budget, output int accepted);
        int cyc;
        accepted = 0;
        cyc = 0;
        while (accepted < n && cyc < budget) begin
            @(negedge ui_clk);
            s_valid = 1'b1;
            s_data  = push_idx;
            #1;
            if (s_ready) begin
                push_idx++;
                accepted++;
            end
            cyc++;
        end
        @(negedge ui_clk);
        s_valid = 1'b0;
    endtask

    task automatic wait_bursts(input int n, input int budget, output bit ok);
        int cyc;
        cyc = 0;
        while (burst_cnt < n && cyc < budget) begin
            @(negedge ui_clk);
            cyc++;
        end
        ok = (burst_cnt >= n);
    endtask

    task automatic test_reset();
        @(negedge ui_clk);
        ui_rst = 1'b1;
        #1;
        tests_run++;
        if (s_ready !== 1'b0) begin tests_failed++; $display("FAIL rst_s_ready got %b exp 0", s_ready); end
        apply_reset();
        #1;
        tests_run++;
        if (fdma_wareq !== 1'b0) begin tests_failed++; $display("FAIL rst_wareq got %b exp 0", fdma_wareq); end
        tests_run++;
        if (fdma_waddr !== BASE) begin tests_failed++; $display("FAIL rst_waddr got %h exp %h", fdma_waddr, BASE); end
        tests_run++;
        if (fifo_level !== 11'd0) begin tests_failed++; $display("FAIL rst_level got %0d exp 0", fifo_level); end
        tests_run++;
        if (burst_cnt !== 32'd0) begin tests_failed++; $display("FAIL rst_burst_cnt got %0d exp 0", burst_cnt); end
        tests_run++;
        if (underflow !== 1'b0) begin tests_failed++; $display("FAIL rst_underflow got %b exp 0", underflow); end
        tests_run++;
        if (s_ready !== 1'b1) begin tests_failed++; $display("FAIL rst_s_ready_after got %b exp 1", s_ready); end
        tests_run++;
        if (fdma_wsize !== 16'd512 || fdma_wready !== 1'b1) begin
            tests_failed++; $display("FAIL rst_consts got wsize %0d wready %b exp 512 1", fdma_wsize, fdma_wready);
        end
    endtask

    task automatic test_two_bursts();
        int acc;
        bit ok;
        logic [127:0] first;
        apply_reset();
        enable = 1'b1;
        model_en = 1'b1;
        push_words(4096, 10000, acc);
        wait_bursts(2, 3000, ok);
        #1;
        tests_run++;
        if (!ok || acc != 4096) begin tests_failed++; $display("FAIL tb_bursts_done got cnt %0d acc %0d exp 2 4096", burst_cnt, acc); end
        first = (got_q.size() > 0) ? got_q[0] : 'x;
        tests_run++;
        if (first !== {32'd3, 32'd2, 32'd1, 32'd0}) begin tests_failed++; $display("FAIL tb_first_beat got %h", first); end
        tests_run++;
        if (count_bad(1024) !== 0) begin tests_failed++; $display("FAIL tb_beats got %0d bad of %0d exp 0 bad of 1024", count_bad(1024), got_q.size()); end
        tests_run++;
        if (addr_q.size() != 2 || addr_q[0] !== BASE || addr_q[1] !== BASE + 32'h2000) begin
            tests_failed++; $display("FAIL tb_addrs got n=%0d first %h exp 2 starting %h", addr_q.size(), (addr_q.size() > 0) ? addr_q[0] : 32'hx, BASE);
        end
        tests_run++;
        if (burst_cnt !== 32'd2 || underflow !== 1'b0 || fifo_level !== 11'd0) begin
            tests_failed++; $display("FAIL tb_status got cnt %0d uf %b lvl %0d exp 2 0 0", burst_cnt, underflow, fifo_level);
        end
    endtask

    task automatic test_backpressure();
        int acc;
        int acc2;
        bit ok;
        apply_reset();
        enable = 1'b1;
        model_en = 1'b0;
        push_words(4200, 4200, acc);
        repeat (5) @(negedge ui_clk);
        #1;
        // 1024 full beats plus three words held in packer lanes 0..2
        tests_run++;
        if (acc != 4099) begin tests_failed++; $display("FAIL bp_accepted got %0d exp 4099", acc); end
        tests_run++;
        if (s_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_s_ready got %b exp 0", s_ready); end
        tests_run++;
        if (fifo_level !== 11'd1024) begin tests_failed++; $display("FAIL bp_level got %0d exp 1024", fifo_level); end
        tests_run++;
        if (fdma_wareq !== 1'b1) begin tests_failed++; $display("FAIL bp_wareq_held got %b exp 1", fdma_wareq); end
        model_en = 1'b1;
        push_words(2045, 10000, acc2);
        wait_bursts(3, 4000, ok);
        #1;
        tests_run++;
        if (!ok || acc2 != 2045) begin tests_failed++; $display("FAIL bp_drain got cnt %0d acc %0d exp 3 2045", burst_cnt, acc2); end
        tests_run++;
        if (count_bad(1536) !== 0) begin tests_failed++; $display("FAIL bp_data got %0d bad of %0d exp 0 bad of 1536", count_bad(1536), got_q.size()); end
        tests_run++;
        if (fifo_level !== 11'd0 || underflow !== 1'b0) begin tests_failed++; $display("FAIL bp_end got lvl %0d uf %b exp 0 0", fifo_level, underflow); end
    endtask

    task automatic test_wrap();
        int acc;
        bit ok;
        apply_reset();
        enable = 1'b1;
        model_en = 1'b1;
        push_words(6144, 15000, acc);
        wait_bursts(3, 3000, ok);
        #1;
        tests_run++;
        if (!ok || burst_cnt !== 32'd3) begin tests_failed++; $display("FAIL wrap_cnt got %0d exp 3", burst_cnt); end
        tests_run++;
        if (addr_q.size() != 3 || addr_q[0] !== BASE || addr_q[1] !== BASE + 32'h2000 || addr_q[2] !== BASE) begin
            tests_failed++; $display("FAIL wrap_addrs got n=%0d last %h exp 3 ending %h", addr_q.size(), (addr_q.size() > 0) ? addr_q[addr_q.size()-1] : 32'hx, BASE);
        end
        tests_run++;
        if (fdma_waddr !== BASE + 32'h2000) begin tests_failed++; $display("FAIL wrap_next_addr got %h exp %h", fdma_waddr, BASE + 32'h2000); end
        tests_run++;
        if (count_bad(1536) !== 0) begin tests_failed++; $display("FAIL wrap_data got %0d bad exp 0", count_bad(1536)); end
    endtask

    task automatic test_enable_gate();
        int acc;
        bit ok;
        apply_reset();
        enable = 1'b0;
        model_en = 1'b1;
        push_words(2048, 5000, acc);
        repeat (10) @(negedge ui_clk);
        #1;
        tests_run++;
        if (fdma_wareq !== 1'b0 || addr_q.size() != 0) begin tests_failed++; $display("FAIL en_no_req got wareq %b reqs %0d exp 0 0", fdma_wareq, addr_q.size()); end
        tests_run++;
        if (fifo_level !== 11'd512) begin tests_failed++; $display("FAIL en_level got %0d exp 512", fifo_level); end
        @(negedge ui_clk);
        enable = 1'b1;
        @(posedge ui_clk);
        #1;
        tests_run++;
        if (fdma_wareq !== 1'b1) begin tests_failed++; $display("FAIL en_wareq_1cyc got %b exp 1", fdma_wareq); end
        // Dropping enable mid-burst lets this burst finish but blocks the next one.
        @(negedge ui_clk);
        enable = 1'b0;
        push_words(2048, 5000, acc);
        wait_bursts(1, 2000, ok);
        repeat (20) @(negedge ui_clk);
        #1;
        tests_run++;
        if (!ok || burst_cnt !== 32'd1 || fdma_wareq !== 1'b0) begin
            tests_failed++; $display("FAIL en_gate_mid got cnt %0d wareq %b exp 1 0", burst_cnt, fdma_wareq);
        end
        tests_run++;
        if (fifo_level !== 11'd512) begin tests_failed++; $display("FAIL en_level2 got %0d exp 512", fifo_level); end
        enable = 1'b1;
        wait_bursts(2, 2000, ok);
        #1;
        tests_run++;
        if (!ok || count_bad(1024) !== 0) begin tests_failed++; $display("FAIL en_data got cnt %0d bad %0d exp 2 0", burst_cnt, count_bad(1024)); end
    endtask

    task automatic test_underflow();
        apply_reset();
        model_en = 1'b0;
        @(negedge ui_clk);
        t_wvalid = 1'b1;
        @(negedge ui_clk);
        t_wvalid = 1'b0;
        #1;
        tests_run++;
        if (underflow !== 1'b1) begin tests_failed++; $display("FAIL uf_set got %b exp 1", underflow); end
        tests_run++;
        if (fifo_level !== 11'd0) begin tests_failed++; $display("FAIL uf_level got %0d exp 0", fifo_level); end
        repeat (5) @(negedge ui_clk);
        #1;
        tests_run++;
        if (underflow !== 1'b1) begin tests_failed++; $display("FAIL uf_sticky got %b exp 1", underflow); end
        apply_reset();
        #1;
        tests_run++;
        if (underflow !== 1'b0) begin tests_failed++; $display("FAIL uf_clear got %b exp 0", underflow); end
    endtask

    task automatic test_reset_mid_burst();
        int acc;
        int cyc;
        bit ok;
        apply_reset();
        enable = 1'b1;
        model_en = 1'b1;
        push_words(2048, 5000, acc);
        cyc = 0;
        while (got_q.size() < 100 && cyc < 2000) begin
            @(negedge ui_clk);
            cyc++;
        end
        tests_run++;
        if (got_q.size() < 100) begin tests_failed++; $display("FAIL rmb_started got %0d beats exp >= 100", got_q.size()); end
        @(negedge ui_clk);
        ui_rst = 1'b1;
        #1;
        tests_run++;
        if (fdma_wareq !== 1'b0 || fifo_level !== 11'd0) begin
            tests_failed++; $display("FAIL rmb_async got wareq %b lvl %0d exp 0 0", fdma_wareq, fifo_level);
        end
        repeat (2) @(negedge ui_clk);
        got_q.delete();
        addr_q.delete();
        push_idx = 0;
        ui_rst = 1'b0;
        push_words(2048, 5000, acc);
        wait_bursts(1, 2000, ok);
        #1;
        tests_run++;
        if (!ok || burst_cnt !== 32'd1) begin tests_failed++; $display("FAIL rmb_cnt got %0d exp 1", burst_cnt); end
        tests_run++;
        if (addr_q.size() != 1 || addr_q[0] !== BASE) begin
            tests_failed++; $display("FAIL rmb_addr got n=%0d %h exp 1 %h", addr_q.size(), (addr_q.size() > 0) ? addr_q[0] : 32'hx, BASE);
        end
        tests_run++;
        if (count_bad(512) !== 0) begin tests_failed++; $display("FAIL rmb_data got %0d bad exp 0", count_bad(512)); end
    endtask

    initial begin
        test_reset();
        test_two_bursts();
        test_backpressure();
        test_wrap();
        test_enable_gate();
        test_underflow();
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
